// File: rtl/event_index_encoder.sv
// event_index_encoder
//
// Registered priority encoder that turns single-cycle event pulses on 2^N
// already-synchronized lines into a serial stream of binary line indices.
// Events are merged into a sticky pending vector. One pending line at a
// time is presented on a valid/ready handshake, and its bit is cleared
// when the index is accepted.
//
// Parameters
//   N            index width; the block has 2^N event lines (N >= 1)
//   ROUND_ROBIN  0 = lowest pending index wins
//                1 = rotating priority starting after the last accepted index
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   evt_in     event pulses, one bit per line
//   idx_out    binary index of the presented line (registered)
//   idx_valid  idx_out holds a valid index (registered)
//   idx_ready  consumer accepts idx_out when idx_valid && idx_ready
//   pending    registered pending vector
//   overflow   one-cycle pulse: an event hit a line that was already pending
module event_index_encoder #(
  parameter int N           = 2,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [(1<<N)-1:0]   evt_in,
  output logic [N-1:0]        idx_out,
  output logic                idx_valid,
  input  logic                idx_ready,
  output logic [(1<<N)-1:0]   pending,
  output logic                overflow
);

  localparam int L = 1 << N;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t         state_q,     state_d;
  logic [L-1:0]   pending_q,   pending_d;
  logic [N-1:0]   idx_q,       idx_d;
  logic           valid_q,     valid_d;
  logic           overflow_q,  overflow_d;
  logic [N-1:0]   last_q,      last_d;

  logic           acc;
  logic [L-1:0]   clr_mask;
  logic [L-1:0]   sel_vec;
  logic           sel_any;
  logic [N-1:0]   sel_idx;
  logic [N-1:0]   rr_base;
  logic [N-1:0]   cand;

  // Pending bookkeeping. The line being accepted is removed from the
  // selection set before new events are merged, so an event arriving on the
  // accepted line re-arms it without counting as an overflow and is only
  // eligible for selection from the next cycle on.
  always_comb begin
    acc      = valid_q && idx_ready;
    clr_mask = '0;
    if (acc) begin
      clr_mask[idx_q] = 1'b1;
    end
    sel_vec    = pending_q & ~clr_mask;
    sel_any    = |sel_vec;
    pending_d  = sel_vec | evt_in;
    overflow_d = |(evt_in & sel_vec);
    last_d     = acc ? idx_q : last_q;
  end

  // Index selection. Both loops run from the lowest-priority candidate to the
  // highest so that the last hit, i.e. the highest-priority one, is kept.
  // In round-robin mode the rotation starts just after the most recently
  // accepted index, including one accepted in this very cycle.
  always_comb begin
    sel_idx = '0;
    rr_base = last_d;
    cand    = '0;
    if (ROUND_ROBIN) begin
      for (int k = L; k >= 1; k--) begin
        cand = rr_base + N'(k);
        if (sel_vec[cand]) begin
          sel_idx = cand;
        end
      end
    end else begin
      for (int i = L - 1; i >= 0; i--) begin
        if (sel_vec[i]) begin
          sel_idx = N'(i);
        end
      end
    end
  end

  // Output state machine. idx_out only moves when a new index is loaded,
  // which happens from IDLE or on an acceptance; otherwise it holds.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          idx_d   = sel_idx;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (acc) begin
          if (sel_any) begin
            idx_d = sel_idx;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      last_q     <= '1;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  assign idx_out   = idx_q;
  assign idx_valid = valid_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/event_index_encoder.md
# event_index_encoder

Registered priority encoder, the inverse of the team's binary-to-one-hot decoder. It collects single-cycle event pulses on 2^N lines (already synchronized into this clock domain) into a sticky pending vector. It then emits the binary index of one pending line at a time over a valid/ready handshake, clearing that line on acceptance. It sits on the receive side of the CDC path, where it turns a vector of synchronized event flags into a serial stream of event indices for downstream logic.

## Interface
- N, 2, index width; block has 2^N event lines (N >= 1)
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority starting after last accepted index
- clk  input  1  rising-edge clock, sole clock of the block
- rst  input  1  synchronous, active-high reset
- evt_in  input  2^N  event pulses; bit i high for one cycle = one event on line i
- idx_out  output  N  binary index of the presented event
- idx_valid  output  1  idx_out holds a valid index
- idx_ready  input  1  consumer accepts idx_out when idx_valid && idx_ready
- pending  output  2^N  registered pending vector (pending_q)
- overflow  output  1  one-cycle pulse: an event was merged into an already-pending line

## Operation
- Accept: acc = idx_valid && idx_ready. clr_mask = one-hot(idx_out) when acc, else 0.
- Pending update every cycle: pending_q <= (pending_q & ~clr_mask) | evt_in.
- Simultaneous event and clear on the same line: the event wins, the bit stays set, and no overflow is flagged.
- Overflow: overflow <= |(evt_in & pending_q & ~clr_mask). The event is merged, not queued. There is no counter.
- Selection source: sel_vec = pending_q & ~clr_mask. evt_in from the same cycle is never in sel_vec.
- Fixed priority (ROUND_ROBIN=0): select the lowest set bit of sel_vec.
- Round robin (ROUND_ROBIN=1): search sel_vec from (last_q+1) mod 2^N upward, with wrap-around.
  - last_q <= idx_out on each acc.
  - last_q resets to 2^N-1, so the first search starts at line 0.
- Output state machine:
  - IDLE (idx_valid=0):
    - if sel_vec != 0: load idx_out with the selected index, set idx_valid=1, go to PRESENT.
    - else: stay in IDLE.
  - PRESENT (idx_valid=1):
    - if !acc: hold idx_out and idx_valid stable.
    - if acc and sel_vec != 0: load the next index, keep idx_valid=1 (back-to-back).
    - if acc and sel_vec == 0: clear idx_valid, go to IDLE. idx_out holds its last value.
- idx_valid never deasserts without acc. idx_out never changes while idx_valid=1 && !idx_ready.
- The presented line's pending bit stays set until acc.

## Timing
- Reset values:
  - pending_q = 0, idx_out = 0, idx_valid = 0, overflow = 0.
  - last_q = 2^N-1, state = IDLE.
- Reset mid-handshake: all pending events and the presented index are dropped.
- evt_in and idx_ready are ignored in any cycle where rst=1.
- Latency: evt_in pulse at edge t → pending bit at t+1 → idx_valid at t+2 (from IDLE with nothing else pending).
- Throughput: one index per cycle while idx_ready=1 and sel_vec is non-zero.
- overflow is registered and asserts the cycle after the offending evt_in.
- All outputs are registered. There is no combinational path from evt_in or idx_ready to any output.

## Test plan
- N=2, fixed priority, reset:
  - stimulus: evt_in=4'b0100 for one cycle, idx_ready=1.
  - required: pending=4'b0100 at t+1; idx_valid=1 and idx_out=2 at t+2; pending=0 and idx_valid=0 after acceptance; overflow stays 0.
- N=2, fixed priority, backpressure then drain:
  - stimulus: evt_in=4'b1011 in one cycle, idx_ready=0 for 5 cycles, then held at 1.
  - required: idx_out=0 held stable through the stall; then 0, 1, 3 on consecutive cycles; idx_valid falls after the third acceptance; pending ends at 0.
- Overflow and same-cycle rules:
  - stimulus 1: line 1 pending but not being presented, evt_in[1] pulsed. Required: overflow=1 for exactly one cycle, pending unchanged.
  - stimulus 2: evt_in[0] pulsed in the same cycle that index 0 is accepted. Required: overflow=0, pending[0] stays 1, index 0 is presented again afterwards.
- N=2, ROUND_ROBIN=1, wrap-around:
  - stimulus: all four lines pending after reset, idx_ready=1; retrigger line 0 after it is accepted.
  - required: output order 0, 1, 2, 3, then 0 (from the retrigger); no line starves.
- Reset mid-operation:
  - stimulus: rst=1 for one cycle while idx_valid=1 with 3 lines pending, and evt_in=4'b1111 during that reset cycle.
  - required: next cycle idx_valid=0, pending=0, overflow=0, idx_out=0; a subsequent evt_in=4'b0010 yields idx_out=1 with standard 2-cycle latency.
